spi_master: RTL

- SPI master (initiator) for the on-chip SPI link; it is the other end of the existing SPI peripheral.
- Drives ss, sclk and mosi, and samples miso.
- Performs one 8-bit full-duplex transfer per start request, in any CPOL/CPHA mode.
- Sits between a local controller (start/data/busy/done handshake) and the SPI pins.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 61 ++++++
 rtl/spi_master.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master.
//   state_t     : FSM state encoding (IDLE, SETUP, XFER, HOLD, DONE), 3 bits
//   CLK_DIV_MIN : smallest usable sclk half-period divider
//   SPI_EDGES   : sclk edges in one 8-bit transfer
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CLK_DIV_MIN = 2;
    localparam int SPI_EDGES   = 16;

endpackage

// File: rtl/spi_clk_gen.sv
// sclk generator for the SPI master.
// A down-counter produces a one-cycle tick every CLK_DIV cycles while run is
// high. On a tick with edge_en high, sclk toggles and the edge is reported as
// leading (sclk leaves idle_level) or trailing (sclk returns to idle_level).
// While run is low the counter is re-armed and sclk follows idle_level.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   run            : counting enable (transfer in progress)
//   edge_en        : allow sclk to toggle on the next tick
//   idle_level     : sclk level when not toggling (CPOL)
//   tick           : end of the current CLK_DIV window
//   sclk           : registered serial clock
//   leading        : tick that moves sclk away from idle_level
//   trailing       : tick that moves sclk back to idle_level
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic edge_en,
    input  logic idle_level,
    output logic tick,
    output logic sclk,
    output logic leading,
    output logic trailing
);

    // Out-of-range dividers are clamped to the smallest usable value.
    localparam int DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN : CLK_DIV;

    logic [7:0] cnt_reg;
    logic       sclk_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= 8'(DIV - 1);
            sclk_reg <= 1'b0;
        end else if (!run) begin
            cnt_reg  <= 8'(DIV - 1);
            sclk_reg <= idle_level;
        end else begin
            if (cnt_reg == 8'd0) begin
                cnt_reg <= 8'(DIV - 1);
            end else begin
                cnt_reg <= cnt_reg - 8'd1;
            end
            if (tick && edge_en) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

    assign tick     = run && (cnt_reg == 8'd0);
    assign leading  = tick && edge_en && (sclk_reg == idle_level);
    assign trailing = tick && edge_en && (sclk_reg != idle_level);
    assign sclk     = sclk_reg;

endmodule

// File: rtl/spi_master.sv
// SPI master: one full-duplex 8-bit transfer per start request, any CPOL/CPHA.
// Sequence: IDLE -> SETUP (CLK_DIV) -> XFER (16 edges) -> HOLD (CLK_DIV)
//           -> DONE (1 cycle) -> IDLE.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   en                : start request, sampled in IDLE only
//   cpol, cpha        : SPI mode, latched at start
//   data_in           : transmit byte, latched at start
//   data_out          : last received byte, updated in DONE
//   busy, done        : handshake (busy SETUP..HOLD, done one-cycle pulse)
//   ss, sclk, mosi    : SPI outputs (all registered)
//   miso              : SPI input
// Build option: SPI_MASTER_LSB_FIRST_EN selects LSB-first shifting in both
// directions; timing and handshake are unchanged.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] tx_reg, rx_reg, data_out_reg;
    logic [4:0]        edge_cnt_reg;
    logic              cpol_reg, cpha_reg;
    logic              ss_reg, busy_reg, done_reg, mosi_reg;

    logic              tick, leading, trailing;
    logic              run, edge_en, idle_level, start, active_next;
    logic              drive, sample;
    logic              tx_first, tx_bit;
    logic [DATA_W-1:0] tx_first_rest, tx_rest, rx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_first      = data_in[0];
    assign tx_first_rest = data_in >> 1;
    assign tx_bit        = tx_reg[0];
    assign tx_rest       = tx_reg >> 1;
    assign rx_next       = {miso, rx_reg[DATA_W-1:1]};
`else
    assign tx_first      = data_in[DATA_W-1];
    assign tx_first_rest = data_in << 1;
    assign tx_bit        = tx_reg[DATA_W-1];
    assign tx_rest       = tx_reg << 1;
    assign rx_next       = {rx_reg[DATA_W-2:0], miso};
`endif

    assign run         = (state_reg == SETUP) || (state_reg == XFER) || (state_reg == HOLD);
    // The SETUP tick is the first sclk edge; XFER toggles until all edges are out.
    assign edge_en     = (state_reg == SETUP) ||
                         ((state_reg == XFER) && (edge_cnt_reg != 5'(SPI_EDGES)));
    // In IDLE sclk tracks the live cpol input; afterwards the latched mode.
    assign idle_level  = (state_reg == IDLE) ? cpol : cpol_reg;
    assign start       = (state_reg == IDLE) && en;
    assign active_next = (state_next == SETUP) || (state_next == XFER) || (state_next == HOLD);
    // CPHA=0 presents the MSB before the first edge, so the final trailing
    // edge has nothing left to shift.
    assign drive       = cpha_reg ? leading
                                  : (trailing && (edge_cnt_reg != 5'(SPI_EDGES - 1)));
    assign sample      = cpha_reg ? trailing : leading;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .edge_en    (edge_en),
        .idle_level (idle_level),
        .tick       (tick),
        .sclk       (sclk),
        .leading    (leading),
        .trailing   (trailing)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = SETUP;
            SETUP:   if (tick) state_next = XFER;
            XFER:    if (tick && (edge_cnt_reg == 5'(SPI_EDGES))) state_next = HOLD;
            HOLD:    if (tick) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ss_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            data_out_reg <= '0;
            tx_reg       <= '0;
            rx_reg       <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            edge_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            ss_reg    <= !active_next;
            busy_reg  <= active_next;
            done_reg  <= (state_next == DONE);
            if (state_next == DONE) begin
                data_out_reg <= rx_reg;
            end
            if (start) begin
                cpol_reg     <= cpol;
                cpha_reg     <= cpha;
                rx_reg       <= '0;
                edge_cnt_reg <= '0;
                if (!cpha) begin
                    mosi_reg <= tx_first;
                    tx_reg   <= tx_first_rest;
                end else begin
                    tx_reg   <= data_in;
                end
            end else begin
                if (leading || trailing) begin
                    edge_cnt_reg <= edge_cnt_reg + 5'd1;
                end
                if (drive) begin
                    mosi_reg <= tx_bit;
                    tx_reg   <= tx_rest;
                end
                if (sample) begin
                    rx_reg <= rx_next;
                end
            end
        end
    end

    assign ss       = ss_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign mosi     = mosi_reg;
    assign data_out = data_out_reg;

endmodule
